// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared definitions for the coordinate-tagged pixel bus. This
//            block and filter_grid both use this package, so they agree on
//            one packing of the bus.
// Contents : COORD_W, PIX_W  - field widths
//            tagged_pix_t    - {y, x, pix}, y in the MSBs
//            tag_state_e     - tagger FSM states
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  localparam int COORD_W = 11;
  localparam int PIX_W   = 12;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [PIX_W-1:0]   pix;
  } tagged_pix_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tag_state_e;

endpackage
`default_nettype wire

// File: rtl/pixel_coord_tagger_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_coord_tagger_if
// Purpose  : Groups the raw pixel stream and the tagged output bus of
//            pixel_coord_tagger.
// Signals  : sof, pix_valid, pix_in           - raw stream (source -> tagger)
//            data_out, data_valid, eol, eof   - tagged stream (tagger -> sink)
//            frame_err, busy                  - status (tagger -> sink)
// Modports : master - pixel source / observer side
//            slave  - the tagger itself
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_coord_tagger_if;
  import pixel_pkg::*;

  logic             sof;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_in;
  tagged_pix_t      data_out;
  logic             data_valid;
  logic             eol;
  logic             eof;
  logic             frame_err;
  logic             busy;

  modport master (
    output sof, pix_valid, pix_in,
    input  data_out, data_valid, eol, eof, frame_err, busy
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output data_out, data_valid, eol, eof, frame_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : raster_counter
// Purpose  : x/y raster position counter. x wraps at LINE_LEN-1 and then
//            bumps y. Both fields wrap to zero after the last position.
// Ports    : clk, rst_n   - clock, async active-low reset
//            inc          - consume one position this cycle
//            clear        - restart at (0,0). When inc is also high, the
//                           (0,0) position is consumed in the same cycle.
//            x, y         - position the current cycle refers to (after clear)
//            at_eol       - x is the last column
//            at_eof       - x/y is the last position of the frame
// Revision : 1.0 - initial release
// ============================================================================
module raster_counter #(
  parameter int LINE_LEN  = 1280,
  parameter int NUM_LINES = 960,
  parameter int CNT_W     = 11
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  input  wire logic             clear,
  output      logic [CNT_W-1:0] x,
  output      logic [CNT_W-1:0] y,
  output      logic             at_eol,
  output      logic             at_eof
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(NUM_LINES - 1);

  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;

  // clear takes effect in the same cycle, so a pixel that arrives together
  // with clear is tagged (0,0) rather than with the stale position.
  always_comb begin
    x      = clear ? '0 : x_q;
    y      = clear ? '0 : y_q;
    at_eol = (x == X_MAX);
    at_eof = at_eol && (y == Y_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (inc) begin
      if (at_eol) begin
        x_q <= '0;
        y_q <= at_eof ? '0 : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end else if (clear) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_coord_tagger.sv
`default_nettype none
// ============================================================================
// Module   : pixel_coord_tagger
// Purpose  : Tags a raw pixel stream with its raster coordinate and emits
//            {y, x, pix} for filter_grid. One cycle latency, no backpressure.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            bus (slave)  - sof/pix_valid/pix_in in. data_out/data_valid/
//                           eol/eof/frame_err/busy out, all registered.
// Params   : IMG_W, IMG_H - active pixels per line / lines per frame
// Revision : 1.0 - initial release
// ============================================================================
module pixel_coord_tagger
  import pixel_pkg::*;
#(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 960
) (
  input wire logic      clk,
  input wire logic      rst_n,
  pixel_coord_tagger_if.slave bus
);

  // Coordinates must never wrap inside a frame.
  if (IMG_W < 1 || IMG_W > (1 << COORD_W)) begin : g_bad_img_w
    $error("IMG_W does not fit the coordinate field");
  end
  if (IMG_H < 1 || IMG_H > (1 << COORD_W)) begin : g_bad_img_h
    $error("IMG_H does not fit the coordinate field");
  end

  tag_state_e         state;
  tag_state_e         next_state;
  logic               accept;
  logic               err;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               at_eol;
  logic               at_eof;

  // sof always restarts the raster, both from IDLE and as a mid-frame abort.
  raster_counter #(
    .LINE_LEN  (IMG_W),
    .NUM_LINES (IMG_H),
    .CNT_W     (COORD_W)
  ) u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (accept),
    .clear  (bus.sof),
    .x      (x),
    .y      (y),
    .at_eol (at_eol),
    .at_eof (at_eof)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state. The last pixel of the frame returns to IDLE even if it
  // arrived with sof (a one-pixel frame).
  always_comb begin
    next_state = state;
    if (state == IDLE && bus.sof) next_state = ACTIVE;
    if (accept && at_eof)         next_state = IDLE;
  end

  // FSM outputs. A pixel is consumed in ACTIVE, or in IDLE when it arrives
  // together with sof.
  always_comb begin
    accept = bus.pix_valid && (state == ACTIVE || bus.sof);
    err    = bus.sof && (state == ACTIVE);
  end

  // Output register. data_out keeps its last value between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.eol        <= 1'b0;
      bus.eof        <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.data_valid <= accept;
      bus.eol        <= accept && at_eol;
      bus.eof        <= accept && at_eof;
      bus.frame_err  <= err;
      bus.busy       <= (next_state == ACTIVE);
      if (accept) begin
        bus.data_out <= '{y: y, x: x, pix: bus.pix_in};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_coord_tagger.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_coord_tagger
// Purpose  : Directed self-checking bench for pixel_coord_tagger. A 5x3
//            instance covers the protocol. A 1280-wide and a 960-tall
//            instance cover the coordinate extremes of the default size.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_coord_tagger;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pixel_coord_tagger_if bus ();
  pixel_coord_tagger_if bus_w ();
  pixel_coord_tagger_if bus_t ();

  pixel_coord_tagger #(.IMG_W(5), .IMG_H(3)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  pixel_coord_tagger #(.IMG_W(1280), .IMG_H(2)) u_wide (
    .clk (clk), .rst_n (rst_n), .bus (bus_w)
  );
  pixel_coord_tagger #(.IMG_W(4), .IMG_H(960)) u_tall (
    .clk (clk), .rst_n (rst_n), .bus (bus_t)
  );

  function automatic logic [33:0] pack(input int y, input int x, input int p);
    return {11'(y), 11'(x), 12'(p)};
  endfunction

  // Apply one cycle of input on the 5x3 instance, then sample after the edge.
  task automatic drive(input logic s, input logic v, input int p);
    bus.sof       = s;
    bus.pix_valid = v;
    bus.pix_in    = 12'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.sof = 1'b0;   bus.pix_valid = 1'b0;   bus.pix_in = '0;
    bus_w.sof = 1'b0; bus_w.pix_valid = 1'b0; bus_w.pix_in = '0;
    bus_t.sof = 1'b0; bus_t.pix_valid = 1'b0; bus_t.pix_in = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.data_out, bus.data_valid, bus.eol, bus.eof, bus.frame_err, bus.busy} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.data_out, bus.data_valid, bus.eol, bus.eof, bus.frame_err, bus.busy});
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.data_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 00", {bus.data_valid, bus.busy});
    end
  endtask

  task automatic test_first_pixel();
    do_reset();
    drive(1'b1, 1'b1, 100);
    checks++;
    if (bus.data_out !== pack(0, 0, 100)) begin
      errors++;
      $display("FAIL first_tag: got %h want %h", bus.data_out, pack(0, 0, 100));
    end
    checks++;
    if ({bus.data_valid, bus.busy, bus.frame_err} !== 3'b110) begin
      errors++;
      $display("FAIL first_flags: got valid/busy/err=%b want 110",
               {bus.data_valid, bus.busy, bus.frame_err});
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(i == 0, 1'b1, i + 1);
      checks++;
      if ({bus.data_valid, bus.data_out} !== {1'b1, pack(i / 5, i % 5, i + 1)}) begin
        errors++;
        $display("FAIL frame_tag[%0d]: got v=%b %h want v=1 %h", i, bus.data_valid,
                 bus.data_out, pack(i / 5, i % 5, i + 1));
      end
      checks++;
      if ({bus.eol, bus.eof} !== {(i % 5) == 4, i == 14}) begin
        errors++;
        $display("FAIL frame_eol_eof[%0d]: got %b want %b", i, {bus.eol, bus.eof},
                 {(i % 5) == 4, i == 14});
      end
      if (i < 14) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_busy[%0d]: got %b want 1", i, bus.busy);
        end
      end
    end
    drive(1'b0, 1'b0, 0);
    checks++;
    if ({bus.busy, bus.data_valid, bus.eol, bus.eof} !== 4'b0000) begin
      errors++;
      $display("FAIL frame_after_eof: got busy/v/eol/eof=%b want 0000",
               {bus.busy, bus.data_valid, bus.eol, bus.eof});
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(i == 0, 1'b1, i + 1);
      checks++;
      if ({bus.data_valid, bus.data_out, bus.eol, bus.eof} !==
          {1'b1, pack(i / 5, i % 5, i + 1), (i % 5) == 4, i == 14}) begin
        errors++;
        $display("FAIL bubble_beat[%0d]: got v=%b %h eol=%b eof=%b want %h eol=%b eof=%b",
                 i, bus.data_valid, bus.data_out, bus.eol, bus.eof,
                 pack(i / 5, i % 5, i + 1), (i % 5) == 4, i == 14);
      end
      drive(1'b0, 1'b0, 999);
      checks++;
      if ({bus.data_valid, bus.eol, bus.eof, bus.data_out} !==
          {3'b000, pack(i / 5, i % 5, i + 1)}) begin
        errors++;
        $display("FAIL bubble_gap[%0d]: got v/eol/eof=%b %h want 000 %h", i,
                 {bus.data_valid, bus.eol, bus.eof}, bus.data_out, pack(i / 5, i % 5, i + 1));
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bubble_busy_end: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_idle_drop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 200);
      checks++;
      if ({bus.data_valid, bus.busy} !== 2'b00) begin
        errors++;
        $display("FAIL idle_drop[%0d]: got valid/busy=%b want 00", i, {bus.data_valid, bus.busy});
      end
    end
    drive(1'b1, 1'b1, 9);
    checks++;
    if ({bus.data_valid, bus.data_out} !== {1'b1, pack(0, 0, 9)}) begin
      errors++;
      $display("FAIL idle_then_sof: got v=%b %h want v=1 %h", bus.data_valid, bus.data_out,
               pack(0, 0, 9));
    end
    drive(1'b0, 1'b1, 10);
    checks++;
    if (bus.data_out !== pack(0, 1, 10)) begin
      errors++;
      $display("FAIL idle_second_pix: got %h want %h", bus.data_out, pack(0, 1, 10));
    end
  endtask

  task automatic test_sof_abort();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 1'b1, i + 1);
      if (i == 0) begin
        checks++;
        if (bus.frame_err !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_err_idle_sof: got %b want 0", bus.frame_err);
        end
      end
    end
    drive(1'b1, 1'b1, 300);
    checks++;
    if ({bus.frame_err, bus.data_valid, bus.busy, bus.data_out} !==
        {3'b111, pack(0, 0, 300)}) begin
      errors++;
      $display("FAIL abort_sof: got err/v/busy=%b %h want 111 %h",
               {bus.frame_err, bus.data_valid, bus.busy}, bus.data_out, pack(0, 0, 300));
    end
    for (int k = 1; k < 15; k++) begin
      drive(1'b0, 1'b1, 300 + k);
      checks++;
      if ({bus.frame_err, bus.eof, bus.data_out} !== {1'b0, k == 14, pack(k / 5, k % 5, 300 + k)}) begin
        errors++;
        $display("FAIL abort_follow[%0d]: got err=%b eof=%b %h want err=0 eof=%b %h", k,
                 bus.frame_err, bus.eof, bus.data_out, k == 14, pack(k / 5, k % 5, 300 + k));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) drive(i == 0, 1'b1, 20 + i);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.data_valid, bus.eol, bus.eof, bus.frame_err, bus.busy} !== 39'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h want 0",
               {bus.data_out, bus.data_valid, bus.eol, bus.eof, bus.frame_err, bus.busy});
    end
    idle_all();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 55);
    checks++;
    if ({bus.frame_err, bus.busy, bus.data_out} !== {2'b01, pack(0, 0, 55)}) begin
      errors++;
      $display("FAIL async_restart: got err/busy=%b %h want 01 %h",
               {bus.frame_err, bus.busy}, bus.data_out, pack(0, 0, 55));
    end
  endtask

  task automatic test_default_size();
    int w_eofs = 0;
    int t_eofs = 0;
    do_reset();
    for (int i = 0; i < 3840; i++) begin
      bus_w.sof = (i == 0); bus_w.pix_valid = 1'b1; bus_w.pix_in = 12'(i);
      bus_t.sof = (i == 0); bus_t.pix_valid = 1'b1; bus_t.pix_in = 12'(i);
      @(posedge clk);
      #1;
      if (bus_w.eof) w_eofs++;
      if (bus_t.eof) t_eofs++;
      if (i == 1279) begin
        checks++;
        if ({bus_w.eol, bus_w.eof, bus_w.data_out} !== {2'b10, pack(0, 1279, 1279)}) begin
          errors++;
          $display("FAIL wide_eol: got eol/eof=%b %h want 10 %h",
                   {bus_w.eol, bus_w.eof}, bus_w.data_out, pack(0, 1279, 1279));
        end
      end
      if (i == 2559) begin
        checks++;
        if ({bus_w.eol, bus_w.eof, bus_w.data_out} !== {2'b11, pack(1, 1279, 2559)}) begin
          errors++;
          $display("FAIL wide_eof: got eol/eof=%b %h want 11 %h",
                   {bus_w.eol, bus_w.eof}, bus_w.data_out, pack(1, 1279, 2559));
        end
      end
      if (i == 2560) begin
        checks++;
        if ({bus_w.data_valid, bus_w.busy} !== 2'b00) begin
          errors++;
          $display("FAIL wide_idle_after: got valid/busy=%b want 00",
                   {bus_w.data_valid, bus_w.busy});
        end
      end
      if (i == 3839) begin
        checks++;
        if ({bus_t.eol, bus_t.eof, bus_t.data_out} !== {2'b11, pack(959, 3, 3839)}) begin
          errors++;
          $display("FAIL tall_eof: got eol/eof=%b %h want 11 %h",
                   {bus_t.eol, bus_t.eof}, bus_t.data_out, pack(959, 3, 3839));
        end
      end
    end
    idle_all();
    checks++;
    if (w_eofs != 1 || t_eofs != 1) begin
      errors++;
      $display("FAIL big_eof_count: got wide=%0d tall=%0d want 1 and 1", w_eofs, t_eofs);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_full_frame();
    test_bubbles();
    test_idle_drop();
    test_sof_abort();
    test_async_reset();
    test_default_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
